// File: rtl/paralelo_serial_if.sv
// -----------------------------------------------------------------------------
// paralelo_serial_if
//   Bundles the load handshake and the serial stream of the parallel-to-serial
//   converter.
//   master : producer/consumer side (drives load_valid, par_in, dir, ser_ready)
//   slave  : converter side (drives load_ready, ser_out, ser_valid, ser_first,
//            ser_last, busy)
// -----------------------------------------------------------------------------
interface paralelo_serial_if #(
    parameter int WIDTH = 5
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] par_in;
    logic             dir;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output load_valid, par_in, dir, ser_ready,
        input  load_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );

    modport slave (
        input  load_valid, par_in, dir, ser_ready,
        output load_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/paralelo_serial.sv
// -----------------------------------------------------------------------------
// paralelo_serial
//   Parallel-in / serial-out converter. A WIDTH-bit word is taken through a
//   valid/ready load handshake and emitted one bit per accepted cycle, LSB
//   first (dir = 0) or MSB first (dir = 1), with first/last word markers.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : paralelo_serial_if.slave (load handshake + serial stream)
// -----------------------------------------------------------------------------
module paralelo_serial #(
    parameter int WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    paralelo_serial_if.slave        bus
);
    localparam int          CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             dir_q,   dir_d;

    logic valid, last, xfer, load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;

        valid = (state_q == SHIFT);
        last  = valid && (cnt_q == LAST);
        xfer  = valid && bus.ser_ready;
        // Ready on the final transfer as well, so words stream with no gap.
        bus.load_ready = (state_q == IDLE) || (last && bus.ser_ready);
        load  = bus.load_valid && bus.load_ready;

        if (xfer) begin
            if (last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d   = cnt_q + CW'(1);
                shreg_d = dir_q ? {shreg_q[WIDTH-2:0], 1'b0}
                                : {1'b0, shreg_q[WIDTH-1:1]};
            end
        end

        // A load can only coincide with the last transfer, so it wins.
        if (load) begin
            state_d = SHIFT;
            shreg_d = bus.par_in;
            dir_d   = bus.dir;
            cnt_d   = '0;
        end

        bus.ser_valid = valid;
        bus.busy      = valid;
        bus.ser_out   = valid && (dir_q ? shreg_q[WIDTH-1] : shreg_q[0]);
        bus.ser_first = valid && (cnt_q == '0);
        bus.ser_last  = last;
    end
endmodule

// File: tb/tb_paralelo_serial.sv
module tb_paralelo_serial;
    localparam int W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    paralelo_serial_if #(.WIDTH(W)) bus ();

    paralelo_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Directed vectors: exp[k] is the serial bit seen on cycle k+1.
    typedef struct {
        logic [W-1:0] par;
        logic         d;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[4];

    // Reference model: a queue of the bits still owed to the consumer.
    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } sbit_t;
    sbit_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word while idle; returns at cycle 1 of that word.
    task automatic load_word(input logic [W-1:0] p, input logic d);
        bus.load_valid = 1'b1;
        bus.par_in     = p;
        bus.dir        = d;
        tick();
        bus.load_valid = 1'b0;
        bus.par_in     = '0;
        bus.dir        = ~d;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic o,
                           input logic f, input logic l);
        chk({tag, ".valid"}, 32'(bus.ser_valid), 32'(v));
        chk({tag, ".busy"},  32'(bus.busy),      32'(v));
        chk({tag, ".out"},   32'(bus.ser_out),   32'(o));
        chk({tag, ".first"}, 32'(bus.ser_first), 32'(f));
        chk({tag, ".last"},  32'(bus.ser_last),  32'(l));
    endtask

    initial begin
        logic [7:0] stall_out, stall_rdy;
        logic [4:0] b2b;
        logic       ev, eo, ef, el, elr, lv, sr;
        logic [W-1:0] p;
        logic       d;

        vecs[0] = '{5'b10110, 1'b0, 5'b10110}; // 0,1,1,0,1
        vecs[1] = '{5'b10110, 1'b1, 5'b01101}; // 1,0,1,1,0
        vecs[2] = '{5'b11001, 1'b1, 5'b10011}; // 1,1,0,0,1
        vecs[3] = '{5'b00001, 1'b0, 5'b00001}; // 1,0,0,0,0

        bus.load_valid = 1'b0;
        bus.par_in     = '0;
        bus.dir        = 1'b0;
        bus.ser_ready  = 1'b0;

        // Reset for two cycles, release away from the edge.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_out("in_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk_out("post_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_reset.load_ready", 32'(bus.load_ready), 32'd1);
        tick();

        // Table-driven single words at full rate.
        bus.ser_ready = 1'b1;
        foreach (vecs[i]) begin
            load_word(vecs[i].par, vecs[i].d);
            for (int k = 0; k < W; k++) begin
                @(negedge clk);
                chk_out($sformatf("vec%0d.c%0d", i, k + 1), 1'b1, vecs[i].exp[k],
                        k == 0, k == W - 1);
                tick();
            end
            @(negedge clk);
            chk_out($sformatf("vec%0d.after", i), 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end

        // Back-to-back: second word held on load_valid, accepted on the last bit.
        load_word(5'b10110, 1'b0);
        bus.load_valid = 1'b1;
        bus.par_in     = 5'b00011;
        bus.dir        = 1'b1;
        b2b = 5'b10110;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk_out($sformatf("b2b.w1.c%0d", k + 1), 1'b1, b2b[k], k == 0, k == W - 1);
            chk($sformatf("b2b.load_ready.c%0d", k + 1), 32'(bus.load_ready),
                32'(k == W - 1));
            tick();
        end
        bus.load_valid = 1'b0;
        bus.par_in     = 5'b11100;
        bus.dir        = 1'b0;
        b2b = 5'b11000; // cycles 6..10 show 0,0,0,1,1
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            chk_out($sformatf("b2b.w2.c%0d", k + 6), 1'b1, b2b[k], k == 0, k == W - 1);
            tick();
        end
        @(negedge clk);
        chk_out("b2b.after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Stall: ser_ready low on cycles 2-4.
        stall_out = 8'b1100_0001; // bit k = cycle k+1: 1,0,0,0,0,0,1,1
        stall_rdy = 8'b1111_0001; // 1,0,0,0,1,1,1,1
        load_word(5'b11001, 1'b0);
        for (int k = 0; k < 8; k++) begin
            bus.ser_ready = stall_rdy[k];
            @(negedge clk);
            chk_out($sformatf("stall.c%0d", k + 1), 1'b1, stall_out[k], k == 0, k == 7);
            tick();
        end
        bus.ser_ready = 1'b1;
        @(negedge clk);
        chk_out("stall.after", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Asynchronous reset in the middle of bit 3.
        load_word(5'b11111, 1'b0);
        repeat (2) begin
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        chk_out("arst.before", 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_out("arst.during", 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            @(negedge clk);
            chk_out($sformatf("arst.after%0d", k), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();

        // Randomized traffic against the bit-queue model.
        q.delete();
        for (int n = 0; n < 3000; n++) begin
            lv = ($urandom_range(0, 1) == 1);
            sr = ($urandom_range(0, 9) < 7);
            p  = W'($urandom);
            d  = 1'($urandom);
            bus.load_valid = lv;
            bus.ser_ready  = sr;
            bus.par_in     = p;
            bus.dir        = d;

            ev  = (q.size() > 0);
            eo  = ev ? q[0].b : 1'b0;
            ef  = ev ? q[0].f : 1'b0;
            el  = ev ? q[0].l : 1'b0;
            elr = (q.size() == 0) || (q.size() == 1 && sr);

            @(negedge clk);
            chk_out($sformatf("rnd%0d", n), ev, eo, ef, el);
            chk($sformatf("rnd%0d.load_ready", n), 32'(bus.load_ready), 32'(elr));

            @(posedge clk);
            if (ev && sr) void'(q.pop_front());
            if (lv && elr) begin
                for (int i = 0; i < W; i++)
                    q.push_back('{b: p[d ? W - 1 - i : i], f: (i == 0), l: (i == W - 1)});
            end
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
